// File: rtl/key_event_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : key_event_gen                                                     |
// | Brief   : Per-key press/short/long/repeat/release pulse generator driven   |
// |           by a shared timing tick. Optional macro KEY_REPEAT_EN enables    |
// |           the auto-repeat (rep_p) generation.                               |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module key_event_gen #(
   parameter int N_KEYS       = 4,
   parameter int LONG_TICKS   = 100,
   parameter int REPEAT_TICKS = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_tick,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] press_p,
   output logic [N_KEYS-1:0] short_p,
   output logic [N_KEYS-1:0] long_p,
   output logic [N_KEYS-1:0] rep_p,
   output logic [N_KEYS-1:0] release_p,
   output logic [N_KEYS-1:0] held
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHORT = 2'd1,
      S_LONG  = 2'd2
   } state_t;

   localparam logic [7:0] c_LONG = 8'(LONG_TICKS);
`ifdef KEY_REPEAT_EN
   localparam logic [7:0] c_REPEAT = 8'(REPEAT_TICKS);
`endif

   generate
      for (genvar g = 0; g < N_KEYS; g++) begin : g_key
         state_t     r_state, w_state_nxt;
         logic [7:0] r_cnt, w_cnt_nxt, w_cnt_inc;
         logic       r_held, r_press, r_short, r_long, r_rel;
         logic       w_rise, w_fall;
         logic       w_press, w_short, w_long, w_rel;

         assign w_rise    = key_in[g] & ~r_held;
         assign w_fall    = ~key_in[g] & r_held;
         assign w_cnt_inc = r_cnt + 8'd1;

`ifdef KEY_REPEAT_EN
         logic r_rep, w_rep;
         assign rep_p[g] = r_rep;
`else
         assign rep_p[g] = 1'b0;
`endif

         always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            w_press     = 1'b0;
            w_short     = 1'b0;
            w_long      = 1'b0;
            w_rel       = 1'b0;
`ifdef KEY_REPEAT_EN
            w_rep       = 1'b0;
`endif
            // Edges take priority over any threshold tick in the same cycle.
            if (w_rise) begin
               w_press     = 1'b1;
               w_cnt_nxt   = 8'd0;
               w_state_nxt = S_SHORT;
            end else if (w_fall) begin
               w_rel       = 1'b1;
               w_short     = (r_state == S_SHORT);
               w_cnt_nxt   = 8'd0;
               w_state_nxt = S_IDLE;
            end else begin
               case (r_state)
                  S_SHORT: begin
                     if (en_tick) begin
                        if (w_cnt_inc == c_LONG) begin
                           w_long      = 1'b1;
                           w_cnt_nxt   = 8'd0;
                           w_state_nxt = S_LONG;
                        end else begin
                           w_cnt_nxt = w_cnt_inc;
                        end
                     end
                  end
                  S_LONG: begin
`ifdef KEY_REPEAT_EN
                     if (en_tick) begin
                        if (w_cnt_inc == c_REPEAT) begin
                           w_rep     = 1'b1;
                           w_cnt_nxt = 8'd0;
                        end else begin
                           w_cnt_nxt = w_cnt_inc;
                        end
                     end
`else
                     w_cnt_nxt = 8'd0;
`endif
                  end
                  default: begin
                     w_cnt_nxt   = 8'd0;
                     w_state_nxt = S_IDLE;
                  end
               endcase
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_state <= S_IDLE;
               r_cnt   <= 8'd0;
               r_held  <= 1'b0;
               r_press <= 1'b0;
               r_short <= 1'b0;
               r_long  <= 1'b0;
               r_rel   <= 1'b0;
`ifdef KEY_REPEAT_EN
               r_rep   <= 1'b0;
`endif
            end else begin
               r_state <= w_state_nxt;
               r_cnt   <= w_cnt_nxt;
               r_held  <= key_in[g];
               r_press <= w_press;
               r_short <= w_short;
               r_long  <= w_long;
               r_rel   <= w_rel;
`ifdef KEY_REPEAT_EN
               r_rep   <= w_rep;
`endif
            end
         end

         assign held[g]      = r_held;
         assign press_p[g]   = r_press;
         assign short_p[g]   = r_short;
         assign long_p[g]    = r_long;
         assign release_p[g] = r_rel;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// Self-checking bench for key_event_gen: directed scenarios plus random traffic,
// compared every cycle against a hold-duration model of the key behaviour.
module tb_key_event_gen;
   localparam int NK = 4;
   localparam int LT = 100;
   localparam int RT = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en_tick = 1'b0;
   logic [NK-1:0] key_in = '0;
   logic [NK-1:0] press_p, short_p, long_p, rep_p, release_p, held;

   key_event_gen #(.N_KEYS(NK), .LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
      .clk(clk), .rst(rst), .en_tick(en_tick), .key_in(key_in),
      .press_p(press_p), .short_p(short_p), .long_p(long_p),
      .rep_p(rep_p), .release_p(release_p), .held(held)
   );

   always #5 clk = ~clk;

   // Model: per key, whether it is pressed and how many ticks it has been held.
   bit            m_held [NK];
   bit            m_act  [NK];
   int            m_ticks[NK];
   logic [NK-1:0] e_press, e_short, e_long, e_rep, e_rel, e_held;

   int n_cmp  = 0;
   int n_fail = 0;
   int ph     = 0;
   int n_long1, n_rep1;

   function automatic void model();
      e_press = '0; e_short = '0; e_long = '0; e_rep = '0; e_rel = '0; e_held = '0;
      for (int k = 0; k < NK; k++) begin
         if (rst) begin
            m_held[k] = 1'b0; m_act[k] = 1'b0; m_ticks[k] = 0;
         end else begin
            if (key_in[k] && !m_held[k]) begin
               e_press[k] = 1'b1; m_act[k] = 1'b1; m_ticks[k] = 0;
            end else if (!key_in[k] && m_held[k]) begin
               e_rel[k] = 1'b1;
               e_short[k] = (m_ticks[k] < LT);
               m_act[k] = 1'b0;
            end else if (m_act[k] && en_tick) begin
`ifdef KEY_REPEAT_EN
               m_ticks[k]++;
               if (m_ticks[k] == LT) e_long[k] = 1'b1;
               else if (m_ticks[k] > LT && ((m_ticks[k] - LT) % RT) == 0) e_rep[k] = 1'b1;
`else
               if (m_ticks[k] < LT) begin
                  m_ticks[k]++;
                  if (m_ticks[k] == LT) e_long[k] = 1'b1;
               end
`endif
            end
            m_held[k] = key_in[k];
            e_held[k] = key_in[k];
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input logic [NK-1:0] keys, input logic tick);
      key_in  = keys;
      en_tick = tick;
      @(posedge clk);
      model();
      @(negedge clk);
      chk("press_p", press_p, e_press);
      chk("short_p", short_p, e_short);
      chk("long_p", long_p, e_long);
      chk("rep_p", rep_p, e_rep);
      chk("release_p", release_p, e_rel);
      chk("held", held, e_held);
      if (long_p[1]) n_long1++;
      if (rep_p[1])  n_rep1++;
   endtask

   // Hold the given key pattern until n ticks (one every 10 clk) have occurred.
   task automatic hold_ticks(input logic [NK-1:0] keys, input int n);
      int t = 0;
      while (t < n) begin
         logic tk;
         tk = (ph == 9);
         ph = (ph + 1) % 10;
         cyc(keys, tk);
         if (tk) t++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc('0, 1'b0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      cyc('0, 1'b0);
      cyc(4'b1111, 1'b1);
      cyc('0, 1'b1);
      rst = 1'b0;
      idle(3);

      // Key0 short press of 50 ticks
      hold_ticks(4'b0001, 50);
      idle(5);

      // Key1 held 145 ticks: long after 100, repeats at 120 and 140 when enabled
      n_long1 = 0; n_rep1 = 0;
      hold_ticks(4'b0010, 145);
      idle(5);
      chk("long1_count", 4'(n_long1), 4'd1);
`ifdef KEY_REPEAT_EN
      chk("rep1_count", 4'(n_rep1), 4'd2);
`else
      chk("rep1_count", 4'(n_rep1), 4'd0);
`endif

      // Key2 released on the same clk as tick 100
      hold_ticks(4'b0100, 99);
      cyc(4'b0000, 1'b1);
      idle(5);

      // Keys 0 and 3 together
      hold_ticks(4'b1001, 105);
      idle(5);

      // Reset mid-hold on key0, key kept pressed through reset
      hold_ticks(4'b0001, 60);
      rst = 1'b1;
      cyc(4'b0001, 1'b0);
      cyc(4'b0001, 1'b1);
      rst = 1'b0;
      hold_ticks(4'b0001, 105);
      idle(3);

      // One-clk glitch and a tick coinciding with a press
      cyc(4'b0010, 1'b1);
      cyc(4'b0000, 1'b0);
      cyc(4'b0100, 1'b1);
      cyc(4'b0100, 1'b1);
      cyc(4'b0000, 1'b0);
      idle(3);

      // Random traffic: long holds with dense ticks, then fast toggling
      for (int i = 0; i < 6000; i++) begin
         logic [NK-1:0] k;
         k = key_in;
         for (int j = 0; j < NK; j++)
            if ($urandom_range(i < 4000 ? 199 : 3, 0) == 0) k[j] = ~k[j];
         rst = ($urandom_range(699, 0) == 0);
         cyc(k, 1'($urandom_range(1, 0)));
      end
      rst = 1'b0;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/key_event_gen.md
# key_event_gen

Per-key press classifier between the switch debouncers and the mode switch multiplexer. Converts each debounced, active-high key level into single-cycle event pulses: press, short-press, long-press, auto-repeat and release. Mode blocks consume these events instead of raw levels, so "hold to fast-advance" and "long-press to enter set mode" behave identically in every mode. All timing counts a shared enable tick, the 100 Hz strobe, not raw clocks.

## Interface

Parameters:
- N_KEYS, 4, number of independent key channels.
- LONG_TICKS, 100, ticks a key must be held before long_p fires; range 2..255.
- REPEAT_TICKS, 20, ticks between successive rep_p pulses after long_p; range 1..255.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- en_tick, input, 1, one-clk timing strobe (100 Hz enable).
- key_in, input, N_KEYS, debounced key levels; 1 = pressed.
- press_p, output, N_KEYS, 1-clk pulse on the press edge.
- short_p, output, N_KEYS, 1-clk pulse on release when held < LONG_TICKS.
- long_p, output, N_KEYS, 1-clk pulse when hold reaches LONG_TICKS.
- rep_p, output, N_KEYS, 1-clk auto-repeat pulse while held past long.
- release_p, output, N_KEYS, 1-clk pulse on every release.
- held, output, N_KEYS, registered key level; mirrors key_in delayed by 1 clk.

## Operation

- Channels are fully independent. No cross-key priority, and several channels may pulse in the same cycle.
- Each channel has a registered previous sample (held), an 8-bit tick counter cnt, and a 2-bit FSM with states IDLE, SHORT, LONG.
- Rise (key_in=1, held=0):
  - press_p=1.
  - cnt cleared to 0.
  - IDLE→SHORT.
- SHORT:
  - On en_tick, cnt increments.
  - When the increment makes cnt==LONG_TICKS: long_p=1, cnt cleared, SHORT→LONG.
- LONG:
  - On en_tick, cnt increments.
  - When the increment makes cnt==REPEAT_TICKS: rep_p=1, cnt cleared, stay in LONG.
- Fall (key_in=0, held=1):
  - release_p=1 from any state.
  - short_p=1 additionally if the state was SHORT.
  - State goes to IDLE, cnt cleared.
- IDLE: cnt holds 0 and en_tick is ignored.
- Simultaneous fall and threshold tick in the same cycle: the fall wins. From SHORT it produces short_p+release_p and no long_p. From LONG it produces release_p and no rep_p.
- Rise and en_tick in the same cycle: the press is recorded and cnt=0; that tick is not counted.
- cnt never exceeds max(LONG_TICKS, REPEAT_TICKS). No wrap is possible.
- A key held through reset deassertion is reported as a fresh press, because held resets to 0.

## Timing

- All outputs are registered. Each pulse is high for exactly one clk.
- press_p / release_p: asserted in the clk after the edge of key_in is sampled, i.e. 1-cycle latency.
- long_p: the clk after the LONG_TICKS-th en_tick following the press.
- rep_p: the clk after every REPEAT_TICKS-th en_tick following long_p.
- short_p is coincident with release_p.
- Reset values: all outputs 0, state IDLE, cnt 0.
- Reset asserted mid-hold aborts silently: no release_p or short_p is emitted.
- Back-to-back edges (1-clk glitch) are legal. The bench sees press_p then release_p+short_p on consecutive cycles.

## Configuration

- KEY_REPEAT_EN defined:
  - rep_p is generated as described.
  - LONG behaves as a repeating state.
- KEY_REPEAT_EN undefined:
  - rep_p is tied to 0.
  - In LONG, cnt is frozen at 0 and en_tick is ignored.
  - The REPEAT_TICKS counter compare logic is removed.
  - All other outputs are unchanged.

## Test plan

All scenarios use LONG_TICKS=100, REPEAT_TICKS=20, and en_tick every 10 clk.

- Key0 held 50 ticks, then released -> one press_p[0], then short_p[0]+release_p[0] in the same clk; no long_p.
- Key1 held 145 ticks with KEY_REPEAT_EN -> long_p[1] one clk after tick 100, rep_p[1] after ticks 120 and 140 (2 pulses); release_p[1] without short_p.
- Same stimulus without KEY_REPEAT_EN -> long_p[1] once, rep_p stays 0 throughout.
- Key2 released in the same clk as tick 100 -> short_p[2]+release_p[2], long_p[2] never asserted.
- Keys 0 and 3 pressed in the same clk -> press_p=4'b1001 in one cycle; their long_p pulses coincide after 100 ticks.
- rst pulsed at tick 60 of a hold on key0, key still held -> all outputs 0 during reset; press_p[0] is reported 1 clk after reset deasserts; long_p[0] follows 100 ticks later.
